// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with multi-cycle busy scoreboard
//
// Purpose:
//   Merges the in-order l3 writeback and out-of-band multi-cycle (mul/div)
//   results onto the single register-file write port. The pipeline write
//   always wins; a colliding multi-cycle result is parked in a 1-entry buffer.
//   A per-register busy scoreboard stalls decode (l2) on RAW/WAW hazards
//   against outstanding multi-cycle destinations.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pipe_we/pipe_rd/pipe_wdata    l3 writeback request
//   mc_issue/mc_issue_rd          multi-cycle op dispatch (marks rd busy)
//   mc_valid/mc_rd/mc_wdata       multi-cycle result, mc_ready accepts it
//   rs1_l2/rs2_l2/rd_l2/rd_we_l2  decode operand indices, stall_l2 out
//   hold_req                      ask upstream for writeback bubbles
//   wr_en/wr_rd/wr_data           register-file write port

module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_wdata,
    input  logic            mc_issue,
    input  logic [4:0]      mc_issue_rd,
    input  logic            mc_valid,
    input  logic [4:0]      mc_rd,
    input  logic [XLEN-1:0] mc_wdata,
    output logic            mc_ready,
    input  logic [4:0]      rs1_l2,
    input  logic [4:0]      rs2_l2,
    input  logic [4:0]      rd_l2,
    input  logic            rd_we_l2,
    output logic            stall_l2,
    output logic            hold_req,
    output logic            wr_en,
    output logic [4:0]      wr_rd,
    output logic [XLEN-1:0] wr_data
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t          state_q, state_d;
    logic [4:0]      buf_rd_q, buf_rd_d;
    logic [XLEN-1:0] buf_data_q, buf_data_d;
    logic [3:0]      starve_q, starve_d;
    logic            hold_req_q, hold_req_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic            pipe_w;
    logic            clr_en;
    logic [4:0]      clr_rd;
    logic            issue_set;
    logic [31:0]     busy_w;

    assign pipe_w    = pipe_we && (pipe_rd != 5'd0);
    assign issue_set = !rst && mc_issue && (mc_issue_rd != 5'd0);
    assign hold_req  = hold_req_q;

    // Zero-extended view of the scoreboard so any 5-bit index can be looked up
    // even when NREG < 32; entry 0 is never busy.
    always_comb begin
        busy_w = '0;
        for (int i = 1; i < NREG; i++) begin
            busy_w[i] = busy_q[i];
        end
    end

    // Arbitration FSM: next state, buffer capture and write-port drive.
    always_comb begin
        state_d    = state_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        starve_d   = starve_q;
        hold_req_d = hold_req_q;
        mc_ready   = 1'b0;
        wr_en      = 1'b0;
        wr_rd      = 5'd0;
        wr_data    = '0;
        clr_en     = 1'b0;
        clr_rd     = 5'd0;

        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    mc_ready = 1'b1;
                    if (pipe_w) begin
                        wr_en   = 1'b1;
                        wr_rd   = pipe_rd;
                        wr_data = pipe_wdata;
                        // Result to x0 is simply dropped, never buffered.
                        if (mc_valid && (mc_rd != 5'd0)) begin
                            buf_rd_d   = mc_rd;
                            buf_data_d = mc_wdata;
                            starve_d   = 4'd0;
                            state_d    = S_HOLD;
                        end
                    end else if (mc_valid && (mc_rd != 5'd0)) begin
                        wr_en   = 1'b1;
                        wr_rd   = mc_rd;
                        wr_data = mc_wdata;
                        clr_en  = 1'b1;
                        clr_rd  = mc_rd;
                    end
                end
                S_HOLD: begin
                    if (pipe_w) begin
                        wr_en   = 1'b1;
                        wr_rd   = pipe_rd;
                        wr_data = pipe_wdata;
                        if (starve_q < STARVE_LIM) begin
                            starve_d = starve_q + 4'd1;
                        end
                        // Registered, so hold_req shows the cycle after the
                        // counter reaches its limit.
                        hold_req_d = (starve_d >= STARVE_LIM);
                    end else begin
                        wr_en      = 1'b1;
                        wr_rd      = buf_rd_q;
                        wr_data    = buf_data_q;
                        clr_en     = 1'b1;
                        clr_rd     = buf_rd_q;
                        starve_d   = 4'd0;
                        hold_req_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Scoreboard update: clear on writeback, then set on issue so that an
    // issue to the register being retired in the same cycle stays busy.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREG; i++) begin
            if (clr_en && (clr_rd == 5'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (issue_set && (mc_issue_rd == 5'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Decode hazard check, including a destination being issued this cycle.
    always_comb begin
        stall_l2 = 1'b0;
        if (!rst) begin
            stall_l2 = busy_w[rs1_l2] || busy_w[rs2_l2] || (rd_we_l2 && busy_w[rd_l2]);
            if (issue_set) begin
                if ((mc_issue_rd == rs1_l2) || (mc_issue_rd == rs2_l2) ||
                    (rd_we_l2 && (mc_issue_rd == rd_l2))) begin
                    stall_l2 = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            buf_rd_q   <= 5'd0;
            buf_data_q <= '0;
            starve_q   <= 4'd0;
            hold_req_q <= 1'b0;
            busy_q     <= '0;
        end else begin
            state_q    <= state_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            starve_q   <= starve_d;
            hold_req_q <= hold_req_d;
            busy_q     <= busy_d;
        end
    end

    // A destination may only be re-issued once its previous result retires;
    // retiring in the same cycle counts as free.
    a_issue_not_busy: assert property (@(posedge clk) disable iff (rst)
        (mc_issue && (mc_issue_rd != 5'd0)) |->
            (!busy_w[mc_issue_rd] || (clr_en && (clr_rd == mc_issue_rd))));

    a_no_x0_write: assert property (@(posedge clk) wr_en |-> (wr_rd != 5'd0));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed scoreboard bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wdata;
    logic        mc_issue;
    logic [4:0]  mc_issue_rd;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_wdata;
    logic        mc_ready;
    logic [4:0]  rs1_l2;
    logic [4:0]  rs2_l2;
    logic [4:0]  rd_l2;
    logic        rd_we_l2;
    logic        stall_l2;
    logic        hold_req;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t pq[$];
    wr_t mq[$];

    int n_assert = 0;
    int n_fail   = 0;

    regfile_wb_arbiter #(
        .XLEN(32),
        .NREG(32),
        .STARVE_MAX(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_rd    (pipe_rd),
        .pipe_wdata (pipe_wdata),
        .mc_issue   (mc_issue),
        .mc_issue_rd(mc_issue_rd),
        .mc_valid   (mc_valid),
        .mc_rd      (mc_rd),
        .mc_wdata   (mc_wdata),
        .mc_ready   (mc_ready),
        .rs1_l2     (rs1_l2),
        .rs2_l2     (rs2_l2),
        .rd_l2      (rd_l2),
        .rd_we_l2   (rd_we_l2),
        .stall_l2   (stall_l2),
        .hold_req   (hold_req),
        .wr_en      (wr_en),
        .wr_rd      (wr_rd),
        .wr_data    (wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pipeline writes are expected first; otherwise the oldest pending
    // multi-cycle result is expected to reach the port.
    task automatic mon(input string tag);
        logic exp_en;
        wr_t  e;
        exp_en = (pq.size() > 0) || (mq.size() > 0);
        chk({tag, "_en"}, {63'd0, wr_en}, {63'd0, exp_en});
        if (exp_en && wr_en) begin
            if (pq.size() > 0) e = pq.pop_front();
            else               e = mq.pop_front();
            chk({tag, "_rd"}, {59'd0, wr_rd}, {59'd0, e.rd});
            chk({tag, "_data"}, {32'd0, wr_data}, {32'd0, e.data});
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pipe(input logic [4:0] rd, input logic [31:0] d);
        wr_t e;
        pipe_we    = 1'b1;
        pipe_rd    = rd;
        pipe_wdata = d;
        e.rd = rd; e.data = d;
        if (rd != 5'd0) pq.push_back(e);
    endtask

    task automatic drive_mc(input logic [4:0] rd, input logic [31:0] d);
        wr_t e;
        mc_valid = 1'b1;
        mc_rd    = rd;
        mc_wdata = d;
        e.rd = rd; e.data = d;
        if (rd != 5'd0) mq.push_back(e);
    endtask

    task automatic idle_inputs();
        pipe_we  = 1'b0; pipe_rd = 5'd0; pipe_wdata = '0;
        mc_issue = 1'b0; mc_issue_rd = 5'd0;
        mc_valid = 1'b0; mc_rd = 5'd0; mc_wdata = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        rs1_l2 = 5'd0; rs2_l2 = 5'd0; rd_l2 = 5'd0; rd_we_l2 = 1'b0;

        // Reset: outputs gated even with a pipeline write present.
        next_cycle();
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wdata = 32'h55;
        #1;
        chk("rst_mc_ready", {63'd0, mc_ready}, 64'd0);
        chk("rst_stall", {63'd0, stall_l2}, 64'd0);
        chk("rst_hold", {63'd0, hold_req}, 64'd0);
        mon("rst_wr");
        next_cycle();
        rst = 1'b0;
        idle_inputs();

        // Plain pipeline write.
        drive_pipe(5'd5, 32'h11);
        #1;
        mon("t1");
        chk("t1_mc_ready", {63'd0, mc_ready}, 64'd1);
        next_cycle();
        idle_inputs();

        // Issue rd 7, hazard stall, then unblocked writeback.
        mc_issue = 1'b1; mc_issue_rd = 5'd7; rs1_l2 = 5'd7;
        #1;
        chk("t2_issue_same_stall", {63'd0, stall_l2}, 64'd1);
        mon("t2_issue");
        next_cycle();
        idle_inputs();
        #1;
        chk("t2_busy_stall", {63'd0, stall_l2}, 64'd1);
        next_cycle();
        drive_mc(5'd7, 32'hABCD);
        #1;
        chk("t2_ready", {63'd0, mc_ready}, 64'd1);
        mon("t2_wb");
        next_cycle();
        idle_inputs();
        #1;
        chk("t2_stall_clear", {63'd0, stall_l2}, 64'd0);
        mon("t2_after");
        rs1_l2 = 5'd0;

        // Collision: pipeline wins, result buffered, drains next cycle.
        mc_issue = 1'b1; mc_issue_rd = 5'd3;
        next_cycle();
        idle_inputs();
        drive_pipe(5'd4, 32'h44);
        drive_mc(5'd3, 32'h33);
        #1;
        mon("t3_coll");
        next_cycle();
        idle_inputs();
        rs2_l2 = 5'd3;
        #1;
        chk("t3_hold_ready", {63'd0, mc_ready}, 64'd0);
        chk("t3_hold_stall", {63'd0, stall_l2}, 64'd1);
        mon("t3_drain");
        next_cycle();
        #1;
        chk("t3_ready_back", {63'd0, mc_ready}, 64'd1);
        chk("t3_stall_clear", {63'd0, stall_l2}, 64'd0);
        mon("t3_after");
        rs2_l2 = 5'd0;

        // Starvation: 4 blocked cycles, hold_req on the 5th.
        mc_issue = 1'b1; mc_issue_rd = 5'd10;
        next_cycle();
        idle_inputs();
        drive_pipe(5'd4, 32'h100);
        drive_mc(5'd10, 32'h1010);
        #1;
        mon("t4_coll");
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            idle_inputs();
            drive_pipe(5'(11 + i), 32'(i + 1));
            #1;
            chk($sformatf("t4_hold_low%0d", i), {63'd0, hold_req}, 64'd0);
            chk($sformatf("t4_ready_low%0d", i), {63'd0, mc_ready}, 64'd0);
            mon($sformatf("t4_starve%0d", i));
        end
        next_cycle();
        idle_inputs();
        #1;
        chk("t4_hold_req", {63'd0, hold_req}, 64'd1);
        mon("t4_drain");
        next_cycle();
        #1;
        chk("t4_hold_clear", {63'd0, hold_req}, 64'd0);
        chk("t4_ready_back", {63'd0, mc_ready}, 64'd1);

        // Re-issue of rd 9 while its buffered result drains: set wins.
        mc_issue = 1'b1; mc_issue_rd = 5'd9;
        next_cycle();
        idle_inputs();
        drive_pipe(5'd2, 32'h22);
        drive_mc(5'd9, 32'h99);
        #1;
        mon("t5_coll");
        next_cycle();
        idle_inputs();
        mc_issue = 1'b1; mc_issue_rd = 5'd9;
        #1;
        mon("t5_drain");
        next_cycle();
        idle_inputs();
        rs2_l2 = 5'd9;
        #1;
        chk("t5_still_busy", {63'd0, stall_l2}, 64'd1);
        drive_mc(5'd9, 32'h999);
        #1;
        mon("t5_second");
        next_cycle();
        idle_inputs();
        #1;
        chk("t5_stall_clear", {63'd0, stall_l2}, 64'd0);
        rs2_l2 = 5'd0;

        // x0 destinations never write.
        drive_mc(5'd0, 32'h5);
        #1;
        chk("t6_x0_ready", {63'd0, mc_ready}, 64'd1);
        mon("t6_mc_x0");
        next_cycle();
        idle_inputs();
        drive_pipe(5'd0, 32'h7);
        #1;
        mon("t6_pipe_x0");
        next_cycle();
        idle_inputs();

        // Reset while holding discards the buffered result.
        mc_issue = 1'b1; mc_issue_rd = 5'd12;
        next_cycle();
        idle_inputs();
        drive_pipe(5'd6, 32'h66);
        drive_mc(5'd12, 32'hC12);
        #1;
        mon("t7_coll");
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        rs1_l2 = 5'd12;
        mq.delete();
        #1;
        chk("t7_rst_ready", {63'd0, mc_ready}, 64'd0);
        chk("t7_rst_stall", {63'd0, stall_l2}, 64'd0);
        mon("t7_rst_wr");
        next_cycle();
        rst = 1'b0;
        #1;
        chk("t7_idle_ready", {63'd0, mc_ready}, 64'd1);
        chk("t7_busy_clear", {63'd0, stall_l2}, 64'd0);
        chk("t7_hold_clear", {63'd0, hold_req}, 64'd0);
        mon("t7_no_drain");
        next_cycle();
        mon("t7_no_drain2");

        chk("sb_pipe_empty", 64'(pq.size()), 64'd0);
        chk("sb_mc_empty", 64'(mq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (stage l3) and a multi-cycle execution unit (mul/div) that returns results out of band.
- Holds a per-register busy scoreboard so decode (stage l2) stalls on RAW/WAW hazards against outstanding multi-cycle results.
- Sits between the l3 writeback mux, the multi-cycle unit and the register file; drives the register file's rd/data/enable.

Parameters:
- XLEN, 32, data width
- NREG, 32, architectural registers (x0 hardwired zero)
- STARVE_MAX, 4, consecutive blocked cycles of a held multi-cycle result before hold_req is raised (range 1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- pipe_we  in  1  l3 writeback valid
- pipe_rd  in  5  l3 destination
- pipe_wdata  in  XLEN  l3 write value (load data or ALU result)
- mc_issue  in  1  multi-cycle op dispatched this cycle
- mc_issue_rd  in  5  its destination
- mc_valid  in  1  multi-cycle result valid
- mc_rd  in  5  result destination
- mc_wdata  in  XLEN  result value
- mc_ready  out  1  arbiter accepts the result this cycle
- rs1_l2  in  5  decode source 1
- rs2_l2  in  5  decode source 2
- rd_l2  in  5  decode destination
- rd_we_l2  in  1  decode instruction writes rd
- stall_l2  out  1  decode must hold
- hold_req  out  1  request upstream to insert writeback bubbles
- wr_en  out  1  register-file write enable
- wr_rd  out  5  register-file write index
- wr_data  out  XLEN  register-file write data

Behaviour:
- pipe_w = pipe_we && pipe_rd != 0. The pipeline write always has priority and is never delayed. When pipe_w is 1, wr_en/wr_rd/wr_data equal pipe_* combinationally in the same cycle.
- FSM states:
  - IDLE (buffer empty): mc_ready = 1.
    - mc_valid && !pipe_w: drive the result to the port in the same cycle; clear busy[mc_rd].
    - mc_valid && pipe_w: capture the result into a 1-entry buffer; go to HOLD.
  - HOLD: mc_ready = 0.
    - !pipe_w: drive the buffer to the port; clear busy[buf_rd]; go to IDLE. mc_ready is 1 the following cycle.
    - pipe_w: remain in HOLD; increment the starve counter (saturating).
- hold_req is registered. It asserts the cycle after the starve counter reaches STARVE_MAX. It clears, and the counter resets, on the cycle the buffer drains. An in-flight pipe_w still wins while hold_req is high.
- A result with mc_rd == 0 is accepted (the handshake completes) but produces wr_en = 0 and enters no buffer. wr_en is never 1 with wr_rd == 0.
- Scoreboard: busy[1..NREG-1], registered.
  - mc_issue with mc_issue_rd != 0 sets busy[rd] at the next edge.
  - Issue and clear of the same rd in one cycle: set wins.
  - busy[0] is constantly 0.
- stall_l2 (combinational) = busy[rs1_l2] || busy[rs2_l2] || (rd_we_l2 && busy[rd_l2]). It also asserts when the same-cycle mc_issue_rd matches any of those nonzero indices. mc_issue to an already-busy rd is illegal (covered by an assertion).
- Reset (rst = 1 at an edge): state IDLE, buffer invalid, busy = 0, counter = 0, hold_req = 0. While rst is high, mc_ready = 0, wr_en = 0 and stall_l2 = 0. A buffered result present at reset is discarded.

Test Plan:
- Reset, then pipe_we=1, pipe_rd=5, pipe_wdata=0x11 → same cycle: wr_en=1, wr_rd=5, wr_data=0x11; mc_ready=1.
- mc_issue rd=7; next cycle rs1_l2=7 → stall_l2=1. Then mc_valid rd=7, data=0xABCD with pipe_we=0 → wr_en=1, wr_rd=7, wr_data=0xABCD same cycle; stall_l2=0 the next cycle.
- mc_valid rd=3, data=0x33 collides with pipe_we rd=4 → port writes rd 4; the result is buffered and mc_ready=0. Next cycle with pipe_we=0 → wr_rd=3, wr_data=0x33. mc_ready=1 the cycle after.
- Buffered result plus pipe_we held high 4 cycles (STARVE_MAX=4) → hold_req=1 on cycle 5. Drop pipe_we → buffer drains; hold_req=0 the next cycle.
- mc_issue rd=9 in the same cycle as the buffered rd=9 result drains → busy[9] stays 1; rs2_l2=9 stalls.
- mc_valid rd=0 → mc_ready=1, wr_en=0. pipe_we rd=0 → wr_en=0. Assert rst while in HOLD → next cycle: IDLE, busy=0, hold_req=0, no write of the buffered value.
